pong_game_ctrl: RTL and testbench

//  Match sequencer for the two-paddle pong game. It sits between the button inputs and the
//  VGA graphics/ball datapath. It gates ball motion and requests ball re-centring after

---
 rtl/pong_game_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Purpose : pong match sequencer; gates ball motion, requests re-centring, keeps BCD scores, picks a winner.
// Latency : every output is registered and reflects the inputs sampled on the previous CLK_50MHZ edge.
// Backpres: none; inputs are single-cycle event pulses that are consumed or ignored in the cycle they arrive.
//
// Ports
//   CLK_50MHZ, RESET_N        system clock, asynchronous active-low reset
//   refr_tick                 one pulse per 60 Hz frame; the only thing that advances the frame counter
//   start_btn                 debounced level; only a rising edge starts a match
//   miss_l / miss_r           ball passed the left / right paddle (point to the other side)
//   ball_reset                one-cycle pulse: reload ball at screen centre
//   ball_en                   level: ball may move on refr_tick (high only in PLAY)
//   serve_dir                 initial x direction after ball_reset (0 = left, 1 = right)
//   score_l / score_r         BCD scores {tens, units}
//   state                     IDLE=0, SERVE=1, PLAY=2, OVER=3
//   winner                    meaningful in OVER: 0 = left, 1 = right
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 300
) (
    input  logic       CLK_50MHZ,
    input  logic       RESET_N,
    input  logic       refr_tick,
    input  logic       start_btn,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       ball_reset,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [7:0] score_l,
    output logic [7:0] score_r,
    output logic [1:0] state,
    output logic       winner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    // Winning score in the same BCD form the score registers use, so the
    // match-point test is a plain equality.
    localparam logic [7:0] WIN_BCD    = 8'(((WIN_SCORE / 10) * 16) + (WIN_SCORE % 10));
    localparam logic [9:0] SERVE_LOAD = 10'(SERVE_FRAMES);
    localparam logic [9:0] OVER_LOAD  = 10'(OVER_FRAMES);

    // BCD +1 with carry from units into tens; 99 holds.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic       start_q;
    logic [9:0] frame_cnt;

    logic       start_edge;
    logic [9:0] cnt_dec;
    logic [7:0] score_l_inc;
    logic [7:0] score_r_inc;

    logic [1:0] nxt_state;
    logic [9:0] nxt_cnt;
    logic [7:0] nxt_score_l;
    logic [7:0] nxt_score_r;
    logic       nxt_dir;
    logic       nxt_winner;
    logic       nxt_ball_reset;

    assign start_edge  = start_btn & ~start_q;
    assign cnt_dec     = (frame_cnt == 10'd0) ? 10'd0 : frame_cnt - 10'd1;
    assign score_l_inc = bcd_inc(score_l);
    assign score_r_inc = bcd_inc(score_r);

    always_comb begin
        nxt_state      = state;
        nxt_cnt        = frame_cnt;
        nxt_score_l    = score_l;
        nxt_score_r    = score_r;
        nxt_dir        = serve_dir;
        nxt_winner     = winner;
        nxt_ball_reset = 1'b0;

        case (state)
            S_IDLE, S_OVER: begin
                // A start edge wins over a simultaneous frame tick.
                if (start_edge) begin
                    nxt_score_l    = 8'h00;
                    nxt_score_r    = 8'h00;
                    nxt_dir        = 1'b1;
                    nxt_ball_reset = 1'b1;
                    nxt_cnt        = SERVE_LOAD;
                    nxt_state      = S_SERVE;
                end else if (refr_tick) begin
                    nxt_cnt = cnt_dec;
                    if (state == S_OVER && frame_cnt == 10'd1)
                        nxt_state = S_IDLE;
                end
            end

            S_SERVE: begin
                if (refr_tick) begin
                    nxt_cnt = cnt_dec;
                    if (frame_cnt == 10'd1)
                        nxt_state = S_PLAY;
                end
            end

            S_PLAY: begin
                // A miss swallows any tick in the same cycle: the counter is reloaded instead.
                if (miss_l && miss_r) begin
                    nxt_dir        = ~serve_dir;
                    nxt_ball_reset = 1'b1;
                    nxt_cnt        = SERVE_LOAD;
                    nxt_state      = S_SERVE;
                end else if (miss_l || miss_r) begin
                    // Serve goes toward the player who missed.
                    if (miss_l) begin
                        nxt_score_r = score_r_inc;
                        nxt_dir     = 1'b0;
                    end else begin
                        nxt_score_l = score_l_inc;
                        nxt_dir     = 1'b1;
                    end
                    if ((miss_l && score_r_inc == WIN_BCD) || (miss_r && score_l_inc == WIN_BCD)) begin
                        nxt_winner = miss_l;
                        nxt_cnt    = OVER_LOAD;
                        nxt_state  = S_OVER;
                    end else begin
                        nxt_ball_reset = 1'b1;
                        nxt_cnt        = SERVE_LOAD;
                        nxt_state      = S_SERVE;
                    end
                end else if (refr_tick) begin
                    nxt_cnt = cnt_dec;
                end
            end

            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            frame_cnt  <= 10'd0;
            start_q    <= 1'b0;
            score_l    <= 8'h00;
            score_r    <= 8'h00;
            serve_dir  <= 1'b1;
            winner     <= 1'b0;
            ball_reset <= 1'b0;
            ball_en    <= 1'b0;
        end else begin
            state      <= nxt_state;
            frame_cnt  <= nxt_cnt;
            start_q    <= start_btn;
            score_l    <= nxt_score_l;
            score_r    <= nxt_score_r;
            serve_dir  <= nxt_dir;
            winner     <= nxt_winner;
            ball_reset <= nxt_ball_reset;
            // Registered alongside state so it is low in the ball_reset cycle.
            ball_en    <= (nxt_state == S_PLAY);
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Purpose : self-checking bench for pong_game_ctrl; two instances (WIN_SCORE 3 and 12) share stimulus.
// Latency : model advances on the same clock edge as the DUTs; compare happens on the falling edge.
// Backpres: none; stimulus is directed pulses followed by random pulses and occasional resets.
module tb_pong_game_ctrl;

    localparam int SERVE_F = 2;
    localparam int OVER_F  = 3;

    logic CLK_50MHZ = 1'b0;
    logic RESET_N   = 1'b1;
    logic refr_tick = 1'b0;
    logic start_btn = 1'b0;
    logic miss_l    = 1'b0;
    logic miss_r    = 1'b0;

    logic       a_ball_reset, a_ball_en, a_serve_dir, a_winner;
    logic [7:0] a_score_l, a_score_r;
    logic [1:0] a_state;
    logic       b_ball_reset, b_ball_en, b_serve_dir, b_winner;
    logic [7:0] b_score_l, b_score_r;
    logic [1:0] b_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    pong_game_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(SERVE_F), .OVER_FRAMES(OVER_F)) dut3 (
        .CLK_50MHZ(CLK_50MHZ), .RESET_N(RESET_N), .refr_tick(refr_tick), .start_btn(start_btn),
        .miss_l(miss_l), .miss_r(miss_r), .ball_reset(a_ball_reset), .ball_en(a_ball_en),
        .serve_dir(a_serve_dir), .score_l(a_score_l), .score_r(a_score_r), .state(a_state),
        .winner(a_winner));

    pong_game_ctrl #(.WIN_SCORE(12), .SERVE_FRAMES(SERVE_F), .OVER_FRAMES(OVER_F)) dut12 (
        .CLK_50MHZ(CLK_50MHZ), .RESET_N(RESET_N), .refr_tick(refr_tick), .start_btn(start_btn),
        .miss_l(miss_l), .miss_r(miss_r), .ball_reset(b_ball_reset), .ball_en(b_ball_en),
        .serve_dir(b_serve_dir), .score_l(b_score_l), .score_r(b_score_r), .state(b_state),
        .winner(b_winner));

    // ---------------- behavioural model (integer scores, frames left) ----------------
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_OVER = 3;

    typedef struct packed {
        int   phase;
        int   pts_l;
        int   pts_r;
        int   frames;
        logic dir;
        logic win;
        logic brst;
        logic sprev;
    } model_t;

    model_t m3, m12;

    function automatic model_t model_reset();
        model_t n;
        n.phase = P_IDLE; n.pts_l = 0; n.pts_r = 0; n.frames = 0;
        n.dir = 1'b1; n.win = 1'b0; n.brst = 1'b0; n.sprev = 1'b0;
        return n;
    endfunction

    function automatic model_t model_step(model_t m, logic st, logic tk, logic ml, logic mr, int win);
        model_t n = m;
        logic pressed = st && !m.sprev;
        n.sprev = st;
        n.brst  = 1'b0;
        if ((m.phase == P_IDLE || m.phase == P_OVER) && pressed) begin
            n.pts_l = 0; n.pts_r = 0; n.dir = 1'b1; n.brst = 1'b1;
            n.frames = SERVE_F; n.phase = P_SERVE;
        end else if (m.phase == P_PLAY && (ml || mr)) begin
            if (ml && mr) n.dir = !m.dir;
            else if (ml) begin n.pts_r = (m.pts_r >= 99) ? 99 : m.pts_r + 1; n.dir = 1'b0; end
            else begin n.pts_l = (m.pts_l >= 99) ? 99 : m.pts_l + 1; n.dir = 1'b1; end
            if (!(ml && mr) && (n.pts_l == win || n.pts_r == win)) begin
                n.phase = P_OVER; n.win = (n.pts_r == win); n.frames = OVER_F;
            end else begin
                n.phase = P_SERVE; n.frames = SERVE_F; n.brst = 1'b1;
            end
        end else if (tk) begin
            if (m.frames == 1 && m.phase == P_SERVE) n.phase = P_PLAY;
            if (m.frames == 1 && m.phase == P_OVER)  n.phase = P_IDLE;
            if (m.frames > 0) n.frames = m.frames - 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [21:0] model_obs(model_t m);
        return {m.phase[1:0], to_bcd(m.pts_l), to_bcd(m.pts_r), (m.phase == P_PLAY) ? 1'b1 : 1'b0,
                m.brst, m.dir, (m.phase == P_OVER) ? m.win : 1'b0};
    endfunction

    always @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            m3  <= model_reset();
            m12 <= model_reset();
        end else begin
            m3  <= model_step(m3,  start_btn, refr_tick, miss_l, miss_r, 3);
            m12 <= model_step(m12, start_btn, refr_tick, miss_l, miss_r, 12);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare of both instances against the model.
    always @(negedge CLK_50MHZ) begin
        if (cmp_en) begin
            chk("model_w3", 32'({a_state, a_score_l, a_score_r, a_ball_en, a_ball_reset, a_serve_dir,
                                 (a_state == 2'd3) ? a_winner : 1'b0}), 32'(model_obs(m3)));
            chk("model_w12", 32'({b_state, b_score_l, b_score_r, b_ball_en, b_ball_reset, b_serve_dir,
                                  (b_state == 2'd3) ? b_winner : 1'b0}), 32'(model_obs(m12)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic st, input logic tk, input logic ml, input logic mr);
        start_btn = st; refr_tick = tk; miss_l = ml; miss_r = mr;
        @(posedge CLK_50MHZ); #1;
        refr_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic serve_out();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic sb;
        #2 RESET_N = 1'b0;
        #1 cmp_en = 1'b1;
        @(posedge CLK_50MHZ); #1;
        @(posedge CLK_50MHZ); #1;
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_scores", 32'({a_score_l, a_score_r}), 32'h0000);
        chk("rst_outs", 32'({a_ball_en, a_ball_reset, a_serve_dir, a_winner}), 32'b0010);
        RESET_N = 1'b1;

        // Start edge -> SERVE with a ball_reset pulse.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_brst", 32'({a_ball_reset, a_state}), 32'({1'b1, 2'd1}));
        chk("start_scores", 32'({a_score_l, a_score_r}), 32'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("brst_one_cycle", 32'({a_ball_reset, a_state}), 32'({1'b0, 2'd1}));
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("serve_tick1", 32'(a_state), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("play_entry", 32'({a_state, a_ball_en}), 32'({2'd2, 1'b1}));

        // Right misses: point to left.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("miss_r_score", 32'(a_score_l), 32'h01);
        chk("miss_r_outs", 32'({a_serve_dir, a_ball_reset, a_ball_en, a_state}), 32'({3'b110, 2'd1}));
        serve_out();

        // Double miss with serve_dir=1.
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("dbl_scores", 32'({a_score_l, a_score_r}), 32'h0100);
        chk("dbl_outs", 32'({a_serve_dir, a_ball_reset, a_state}), 32'({2'b01, 2'd1}));

        // Misses and a fresh start edge during SERVE are ignored.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("serve_ignore", 32'({a_score_l, a_score_r, a_state, a_ball_reset}), 32'({16'h0100, 2'd1, 1'b0}));
        serve_out();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        serve_out();

        // Left reaches 3 on the WIN_SCORE=3 instance.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("win_state", 32'({a_state, a_winner, a_ball_reset}), 32'({2'd3, 1'b0, 1'b0}));
        chk("win_score", 32'(a_score_l), 32'h03);
        chk("no_win_w12", 32'({b_state, b_ball_reset}), 32'({2'd1, 1'b1}));
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("over_hold", 32'(a_state), 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("over_to_idle", 32'(a_state), 32'd0);
        chk("idle_scores", 32'(a_score_l), 32'h03);

        // Start held high in IDLE must not retrigger.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("held_start", 32'({a_state, a_ball_reset}), 32'({2'd0, 1'b0}));

        // Alternating points on the WIN_SCORE=12 instance: BCD carry, no early winner.
        for (int k = 4; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            if (k == 8)  chk("bcd_08", 32'(b_score_l), 32'h08);
            if (k == 9)  chk("bcd_09", 32'(b_score_l), 32'h09);
            if (k == 10) chk("bcd_10", 32'(b_score_l), 32'h10);
            chk("no_early_win", 32'(b_state), 32'd1);
            serve_out();
            if (k < 10) begin
                cyc(1'b1, 1'b0, 1'b1, 1'b0);
                serve_out();
            end
        end
        chk("w12_score_r", 32'(b_score_r), 32'h06);

        // Asynchronous reset in the middle of PLAY.
        chk("pre_rst_play", 32'(b_state), 32'd2);
        #5 RESET_N = 1'b0;
        #1;
        chk("async_rst", 32'({b_state, b_score_l, b_score_r, b_ball_en, b_ball_reset, b_serve_dir, b_winner}),
            32'({2'd0, 16'h0000, 4'b0010}));
        start_btn = 1'b0;
        @(posedge CLK_50MHZ); #1;
        RESET_N = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fresh_start", 32'({b_state, b_ball_reset, b_score_l}), 32'({2'd1, 1'b1, 8'h00}));

        // Random phase, checked by the continuous compare.
        sb = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                RESET_N = 1'b0;
                @(posedge CLK_50MHZ); #1;
                RESET_N = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) sb = !sb;
            cyc(sb, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        @(negedge CLK_50MHZ);
        #1 cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
